pipelined_2x4_decoder: RTL and testbench

//   Receive end of the priority-encoder interface: converts {code, valid} words back into one-hot lines.

---
 rtl/pipelined_2x4_decoder.sv | 92 +++++++++
 tb/tb_pipelined_2x4_decoder.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/pipelined_2x4_decoder.sv
// Receive side of the priority-encoder link: buffers {code} words in a small
// FIFO and hands them out as one-hot lines through a valid/ready handshake.
// All handshake flags come from registered state, so there is no
// combinational path from the input handshake to the output handshake.
module pipelined_2x4_decoder #(
    parameter int N     = 2,
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     in_code,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [2**N-1:0]  out_onehot,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] dec_count,
    output logic             full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [AW-1:0]  PTR_ONE  = AW'(1);
    localparam logic [AW:0]    OCC_ONE  = (AW + 1)'(1);
    localparam logic [AW:0]    OCC_FULL = (AW + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [N-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   occupancy;
    logic          push;
    logic          pop;
    logic [N-1:0]  head;

    // Flags are pure functions of the registered occupancy.
    always_comb begin
        full      = (occupancy == OCC_FULL);
        in_ready  = ~full;
        out_valid = (occupancy != '0);
        push      = in_valid & in_ready;
        pop       = out_valid & out_ready;
        head      = mem[rd_ptr];
    end

    // One-hot decode of the head entry, forced to zero when nothing is buffered.
    always_comb begin
        out_onehot = '0;
        if (out_valid) begin
            out_onehot[head] = 1'b1;
        end
    end

    // Storage array; contents need no reset because occupancy guards every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_code;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leaves occupancy unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push && !pop) begin
                occupancy <= occupancy + OCC_ONE;
            end else if (pop && !push) begin
                occupancy <= occupancy - OCC_ONE;
            end
        end
    end

    // Delivered-word counter, wraps silently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dec_count <= '0;
        end else if (pop) begin
            dec_count <= dec_count + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_pipelined_2x4_decoder.sv
// Bench for pipelined_2x4_decoder: directed and random traffic checked
// against a queue-based reference model of the buffered words.
module tb_pipelined_2x4_decoder;

    localparam int N     = 2;
    localparam int DEPTH = 2;
    localparam int CNT_W = 8;

    logic             clk;
    logic             rst;
    logic [N-1:0]     in_code;
    logic             in_valid;
    logic             in_ready;
    logic [2**N-1:0]  out_onehot;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] dec_count;
    logic             full;

    int checks;
    int errors;
    int model_q[$];
    int model_count;

    pipelined_2x4_decoder #(.N(N), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_code    (in_code),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_onehot (out_onehot),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .dec_count  (dec_count),
        .full       (full)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts, reports and flags any difference.
    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("[TB] check %s differs", tag);
        end
    endtask

    // Compares every output against the reference queue.
    task automatic checkOutput(input string tag);
        logic [31:0] exp_onehot;
        logic [31:0] exp_count;
        exp_onehot = (model_q.size() > 0) ? (32'd1 << model_q[0]) : 32'd0;
        exp_count  = 32'(model_count % (1 << CNT_W));
        checkVal({tag, ".in_ready"},   {31'd0, in_ready},   {31'd0, model_q.size() < DEPTH});
        checkVal({tag, ".out_valid"},  {31'd0, out_valid},  {31'd0, model_q.size() > 0});
        checkVal({tag, ".full"},       {31'd0, full},       {31'd0, model_q.size() == DEPTH});
        checkVal({tag, ".out_onehot"}, {28'd0, out_onehot}, exp_onehot);
        checkVal({tag, ".dec_count"},  {24'd0, dec_count},  exp_count);
    endtask

    // Drives one cycle of inputs (called while clk is low), checks, then advances the model.
    task automatic applyStimulus(input string tag, input logic v, input logic [N-1:0] code,
                                 input logic rdy);
        bit do_push;
        bit do_pop;
        in_valid  = v;
        in_code   = code;
        out_ready = rdy;
        #1;
        checkOutput(tag);
        do_push = v && (model_q.size() < DEPTH);
        do_pop  = rdy && (model_q.size() > 0);
        @(posedge clk);
        if (do_pop) begin
            void'(model_q.pop_front());
            model_count++;
        end
        if (do_push) begin
            model_q.push_back(int'(code));
        end
        @(negedge clk);
    endtask

    // Asserts reset in the middle of the low phase and checks the outputs clear at once.
    task automatic asyncReset(input string tag);
        #2;
        rst = 1'b1;
        model_q.delete();
        model_count = 0;
        #1;
        checkOutput(tag);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int budget;
        checks      = 0;
        errors      = 0;
        model_count = 0;
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_code     = '0;
        out_ready   = 1'b0;

        // Power-on reset state
        @(negedge clk);
        checkOutput("reset_init");
        rst = 1'b0;

        // Single word: code 2 -> 0100, then empty with dec_count=1
        applyStimulus("single_push", 1'b1, 2'b10, 1'b1);
        applyStimulus("single_out",  1'b0, 2'b00, 1'b1);
        applyStimulus("single_done", 1'b0, 2'b00, 1'b1);
        checkVal("single_count", {24'd0, dec_count}, 32'd1);

        // Sweep all codes back-to-back
        for (int c = 0; c < 4; c++) begin
            applyStimulus("sweep", 1'b1, N'(c), 1'b1);
        end
        applyStimulus("sweep_tail", 1'b0, 2'b00, 1'b1);
        applyStimulus("sweep_end",  1'b0, 2'b00, 1'b1);
        checkVal("sweep_count", {24'd0, dec_count}, 32'd5);

        // Backpressure: fill, refused third push, then drain
        applyStimulus("bp_push1",   1'b1, 2'b11, 1'b0);
        applyStimulus("bp_push2",   1'b1, 2'b01, 1'b0);
        applyStimulus("bp_refused", 1'b1, 2'b00, 1'b0);
        checkVal("bp_full", {31'd0, full}, 32'd1);
        applyStimulus("bp_drain1",  1'b1, 2'b00, 1'b1);
        applyStimulus("bp_accept",  1'b1, 2'b00, 1'b1);
        applyStimulus("bp_drain2",  1'b0, 2'b00, 1'b1);
        applyStimulus("bp_empty",   1'b0, 2'b00, 1'b1);

        // in_valid low with a live-looking code stores nothing
        for (int i = 0; i < 5; i++) begin
            applyStimulus("idle", 1'b0, 2'b11, 1'($urandom_range(0, 1)));
        end

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            applyStimulus("random", 1'($urandom_range(0, 1)), N'($urandom_range(0, 3)),
                          ($urandom_range(0, 3) != 0));
        end

        // Mid-cycle reset after traffic
        asyncReset("reset_mid");

        // Counter wrap: stream until 256 pops have been delivered
        budget = 0;
        while (model_count < 256 && budget < 1000) begin
            applyStimulus("wrap", 1'b1, N'($urandom_range(0, 3)), 1'b1);
            budget++;
        end
        checkVal("wrap_budget", {31'd0, model_count < 256}, 32'd0);
        checkVal("wrap_count", {24'd0, dec_count}, 32'(model_count % 256));
        applyStimulus("wrap_drain", 1'b0, 2'b00, 1'b1);
        applyStimulus("wrap_idle",  1'b0, 2'b00, 1'b1);

        // Reset with two words buffered discards both
        applyStimulus("rst_fill1", 1'b1, 2'b01, 1'b0);
        applyStimulus("rst_fill2", 1'b1, 2'b10, 1'b0);
        checkVal("rst_prefull", {31'd0, full}, 32'd1);
        asyncReset("reset_full");
        for (int i = 0; i < 3; i++) begin
            applyStimulus("post_reset", 1'b0, 2'b00, 1'b1);
        end
        applyStimulus("post_push", 1'b1, 2'b11, 1'b1);
        applyStimulus("post_out",  1'b0, 2'b00, 1'b1);
        applyStimulus("post_end",  1'b0, 2'b00, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
